// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The master drives operation requests and MTHI/MTLO writes; the slave returns status and HI/LO.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] Op1;
  logic [XLEN-1:0] Op2;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output start, op, Op1, Op2, mthi, mtlo, wdata,
    input  busy, done, div_by_zero, HI, LO
  );

  modport slave (
    input  start, op, Op1, Op2, mthi, mtlo, wdata,
    output busy, done, div_by_zero, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 shift-add or restoring-divide steps on operand
// magnitudes, then a sign-fix cycle that writes the architectural HI/LO registers.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_count;

  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_op1;
  logic              r_op2_neg;
  logic [XLEN-1:0]   r_mag_m;
  logic [XLEN-1:0]   r_acc_hi;
  logic [XLEN-1:0]   r_acc_lo;

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_done;
  logic              r_dz;

  logic              w_is_div;
  logic              w_is_signed;
  logic              w_start_is_signed;
  logic              w_start_is_div;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_sh;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;

  logic              w_sign_diff;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic              w_dz;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  // Two's-complement magnitude; the most negative value maps onto itself as an unsigned magnitude.
  function automatic logic [XLEN-1:0] f_mag(input logic signed [XLEN-1:0] x,
                                            input logic                   is_signed);
    logic [XLEN-1:0] r;
    r = (is_signed && x[XLEN-1]) ? XLEN'(-x) : XLEN'(x);
    return r;
  endfunction

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] f_cneg_wide(input logic [2*XLEN-1:0] x, input logic neg);
    return neg ? (~x + (2*XLEN)'(1)) : x;
  endfunction

  assign w_is_div          = r_op[1];
  assign w_is_signed       = ~r_op[0];
  assign w_start_is_div    = bus.op[1];
  assign w_start_is_signed = ~bus.op[0];
  assign w_mag1            = f_mag(bus.Op1, w_start_is_signed);
  assign w_mag2            = f_mag(bus.Op2, w_start_is_signed);

  // Multiply step: conditionally add multiplicand into the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_m} : '0);

  // Divide step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_div_sh   = {r_acc_hi, r_acc_lo[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_mag_m};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_mag_m});

  always_comb begin
    w_step_hi = r_acc_hi;
    w_step_lo = r_acc_lo;
    if (w_is_div) begin
      w_step_hi = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
      w_step_lo = {r_acc_lo[XLEN-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[XLEN:1];
      w_step_lo = {w_mul_sum[0], r_acc_lo[XLEN-1:1]};
    end
  end

  assign w_sign_diff = r_op1[XLEN-1] ^ r_op2_neg;
  assign w_prod_fix  = f_cneg_wide({r_acc_hi, r_acc_lo}, w_is_signed & w_sign_diff);
  assign w_quot_fix  = f_cneg(r_acc_lo, w_is_signed & w_sign_diff);
  assign w_rem_fix   = f_cneg(r_acc_hi, w_is_signed & r_op1[XLEN-1]);
  assign w_dz        = w_is_div && (r_mag_m == '0);

  always_comb begin
    w_fix_hi = w_prod_fix[2*XLEN-1:XLEN];
    w_fix_lo = w_prod_fix[XLEN-1:0];
    if (w_dz) begin
      w_fix_hi = r_op1;
      w_fix_lo = '1;
    end else if (w_is_div) begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = w_quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (r_count == 5'd31) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control and architectural state: iteration count, HI/LO, completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_count <= '0;
          end else begin
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        S_RUN: r_count <= r_count + 5'd1;
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
          r_dz   <= w_dz;
        end
        default: r_count <= '0;
      endcase
    end
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_op      <= bus.op;
      r_op1     <= bus.Op1;
      r_op2_neg <= bus.Op2[XLEN-1];
      r_mag_m   <= w_start_is_div ? w_mag2 : w_mag1;
      r_acc_hi  <= '0;
      r_acc_lo  <= w_start_is_div ? w_mag1 : w_mag2;
    end else if (r_state == S_RUN) begin
      r_acc_hi  <= w_step_hi;
      r_acc_lo  <= w_step_lo;
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dz;
  assign bus.HI          = r_hi;
  assign bus.LO          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a latency-counting arithmetic model checked every cycle,
// directed literal cases, and a randomized phase with interference and resets.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  function automatic void cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the instruction definitions, using 64-bit integers.
  function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    dz = 1'b0;
    case (op)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) dz = 1'b1;
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else p = {a % b, a / b};
      end
    endcase
    if (dz) p = {a, 32'hFFFF_FFFF};
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Cycle model: an accepted start produces its result 33 edges later; nothing else moves HI/LO
  // except MTHI/MTLO while idle and not starting.
  logic        m_busy, m_done, m_dz, m_res_dz;
  int          m_cnt;
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;

  always @(posedge clk) begin
    m_done = 1'b0;
    m_dz   = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_hi   = m_res_hi;
        m_lo   = m_res_lo;
        m_done = 1'b1;
        m_dz   = m_res_dz;
      end
    end else if (bus.start) begin
      m_busy = 1'b1;
      m_cnt  = 33;
      ref_calc(bus.op, bus.Op1, bus.Op2, m_res_hi, m_res_lo, m_res_dz);
    end else begin
      if (bus.mthi) m_hi = bus.wdata;
      if (bus.mtlo) m_lo = bus.wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 32'(bus.busy), 32'(m_busy));
      cmp("done", 32'(bus.done), 32'(m_done));
      cmp("div_by_zero", 32'(bus.div_by_zero), 32'(m_dz));
      cmp("HI", bus.HI, m_hi);
      cmp("LO", bus.LO, m_lo);
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mth, input logic [31:0] wd);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.Op1   = a;
    bus.Op2   = b;
    bus.mthi  = mth;
    bus.wdata = wd;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_done(output logic [31:0] h, output logic [31:0] l, output logic dz,
                           output int cyc);
    int n;
    cyc = 0;
    n   = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) cyc++;
      n++;
      @(negedge clk);
    end
    if (!bus.done) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout got=0 expected=1 at %0t", $time);
    end
    h  = bus.HI;
    l  = bus.LO;
    dz = bus.div_by_zero;
  endtask

  task automatic run_lit(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz);
    logic [31:0] h, l;
    logic dz;
    int cyc;
    launch(op, a, b, 1'b0, 32'd0);
    wait_done(h, l, dz, cyc);
    cmp({nm, "_HI"}, h, eh);
    cmp({nm, "_LO"}, l, el);
    cmp({nm, "_dz"}, 32'(dz), 32'(edz));
    cmp({nm, "_busy_cycles"}, 32'(cyc), 32'd33);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom % 16);
      5:       return 32'hFFFF_FFF0 | 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] h, l;
    logic dz;
    int cyc;

    rst       = 1'b1;
    bus.op    = 2'd0;
    bus.Op1   = '0;
    bus.Op2   = '0;
    bus.wdata = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;
    cmp("reset_HI", bus.HI, 32'h0);
    cmp("reset_LO", bus.LO, 32'h0);
    cmp("reset_busy", 32'(bus.busy), 32'd0);

    run_lit("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    cmp("done_width", 32'(bus.done), 32'd0);
    run_lit("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_lit("mult_minxmin", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_lit("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_lit("div_minbyneg1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_lit("divu_100by7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_lit("divu_10by0", 2'd3, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);

    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    idle_inputs();
    cmp("mthi_HI", bus.HI, 32'h0000_1234);

    launch(2'd1, 32'd2, 32'd3, 1'b0, 32'd0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd3;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    wait_done(h, l, dz, cyc);
    cmp("busy_ignore_HI", h, 32'h0);
    cmp("busy_ignore_LO", l, 32'h6);

    launch(2'd1, 32'd1, 32'd1, 1'b1, 32'h5555_5555);
    wait_done(h, l, dz, cyc);
    cmp("start_beats_mthi_HI", h, 32'h0);
    cmp("start_beats_mthi_LO", l, 32'h1);

    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", 32'(bus.busy), 32'd0);
    cmp("abort_HI", bus.HI, 32'h0);
    cmp("abort_LO", bus.LO, 32'h0);
    cmp("abort_done", 32'(bus.done), 32'd0);
    run_lit("after_abort", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = (($urandom % 6) == 0);
      bus.op    = 2'($urandom);
      bus.Op1   = pick();
      bus.Op2   = pick();
      bus.mthi  = (($urandom % 5) == 0);
      bus.mtlo  = (($urandom % 5) == 0);
      bus.wdata = $urandom;
      rst       = (($urandom % 400) == 0);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the EX stage, alongside the ALU. It takes the same rs/rt operands the ALU receives from the ID/EX register, runs MULT/MULTU/DIV/DIVU over 33 cycles, and holds results in the architectural HI/LO registers. HI/LO feed the ALU Op2 source mux for MFHI/MFLO. `busy` drives the hazard unit's stall of any HI/LO-dependent instruction.

## Interface

Parameters:
- XLEN, 32, operand/result width (only 32 supported)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- Op1  in  32  rs operand (multiplicand / dividend)
- Op2  in  32  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI (MTHI)
- mtlo  in  1  write wdata to LO (MTLO)
- wdata  in  32  MTHI/MTLO data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when HI/LO receive a result
- div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU had Op2 == 0
- HI  out  32  HI register
- LO  out  32  LO register

## Operation

- Reset (rst=1 at an edge): state=IDLE, count=0, HI=LO=0, busy=done=div_by_zero=0. Any in-flight operation is abandoned, with no partial HI/LO write.
- States:
  - IDLE: on start, latch op, Op1, Op2; go to RUN with count=0.
  - RUN: one iteration per cycle for 32 cycles (count 0..31); go to FIX at count=31.
  - FIX: apply sign correction, write HI/LO, pulse done; return to IDLE.
- Operands are latched at start. Input changes during RUN/FIX have no effect.
- Signed ops (MULT, DIV) iterate on magnitudes. Take |x| via two's complement; 0x80000000 maps to magnitude 0x80000000 unsigned.
- Multiply: shift-add, 64-bit product. FIX negates the full 64-bit product if sign(Op1) ≠ sign(Op2) for MULT. HI = product[63:32], LO = product[31:0].
- Divide: restoring, 1 quotient bit per cycle. Quotient goes to LO, remainder to HI.
  - Signed quotient is negated if sign(Op1) ≠ sign(Op2).
  - Signed remainder takes the sign of Op1.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (32-bit wrap, no trap).
- Divide by zero: iterations still run, with the same latency. FIX forces LO=0xFFFFFFFF and HI=Op1 (raw latched value, signed or unsigned), and pulses div_by_zero=1 with done.
- MTHI/MTLO:
  - Applied only in IDLE with start=0; both may be set in the same cycle.
  - Ignored while busy.
  - If start and mthi/mtlo are asserted together in IDLE, start wins and the writes are dropped.
- start while busy is ignored; it is not queued.
- HI/LO hold their values except on a FIX write, an MTHI/MTLO write, or reset.

## Timing

- Edge E0 samples start in IDLE. busy=1 from after E0.
- E1..E32: 32 RUN iterations. E32 transitions to FIX.
- E33: HI/LO written, state to IDLE. After E33: done=1 (and div_by_zero if applicable) and busy=0 in the same cycle. New HI/LO are visible in that cycle.
- Result latency: 33 cycles from the start edge. Back-to-back: a new start may be accepted at E34 (the cycle where done=1).
- done and div_by_zero are low in every other cycle.
- An MTHI/MTLO write is visible on HI/LO the cycle after the edge that applies it.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001, done pulse width 1, busy high for exactly 33 cycles.
- MULT -3 (0xFFFFFFFD) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Also MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 10 / 0 -> LO=0xFFFFFFFF, HI=0x0000000A, div_by_zero=1 coincident with done, same 33-cycle latency.
- MTHI 0x1234 in IDLE -> HI=0x1234 next cycle. Start MULTU 2×3, then in cycle 5 assert start (op=DIVU) and mtlo=1 -> both ignored, result HI=0, LO=6. Then start together with mthi in IDLE -> mthi dropped.
- Start MULTU, assert rst at cycle 10 -> next cycle busy=0, HI=LO=0, no done. A fresh start then completes normally in 33 cycles.
